// File: rtl/commit_store_queue_if.sv
// commit_store_queue_if
//   Groups the commit store queue's non-clock signals: the LSU allocation
//   port, the commit-stage handshake, the load page-offset hazard probe and
//   the D$ write request channel. Signal names match the queue's own port
//   names so existing connections map one-to-one.
//   slave  : the queue's view (drives *_o, samples *_i).
//   master : the surrounding pipeline's view (LSU, commit stage, D$).
interface commit_store_queue_if #(
  parameter int unsigned PADDR_W = 56
) ();

  // pipeline control
  logic               flush_i;

  // LSU allocation port
  logic               st_valid_i;
  logic               st_ready_o;
  logic [PADDR_W-1:0] st_paddr_i;
  logic [63:0]        st_data_i;
  logic [7:0]         st_be_i;
  logic [1:0]         st_size_i;

  // commit stage handshake
  logic               commit_i;
  logic               commit_ready_o;
  logic               no_st_pending_o;

  // load hazard probe
  logic [11:0]        page_offset_i;
  logic               page_offset_match_o;

  // D$ write request
  logic               req_o;
  logic               gnt_i;
  logic [PADDR_W-1:0] req_paddr_o;
  logic [63:0]        req_data_o;
  logic [7:0]         req_be_o;
  logic [1:0]         req_size_o;

  modport slave (
    input  flush_i,
    input  st_valid_i, st_paddr_i, st_data_i, st_be_i, st_size_i,
    output st_ready_o,
    input  commit_i,
    output commit_ready_o, no_st_pending_o,
    input  page_offset_i,
    output page_offset_match_o,
    output req_o, req_paddr_o, req_data_o, req_be_o, req_size_o,
    input  gnt_i
  );

  modport master (
    output flush_i,
    output st_valid_i, st_paddr_i, st_data_i, st_be_i, st_size_i,
    input  st_ready_o,
    output commit_i,
    input  commit_ready_o, no_st_pending_o,
    output page_offset_i,
    input  page_offset_match_o,
    input  req_o, req_paddr_o, req_data_o, req_be_o, req_size_o,
    output gnt_i
  );

endinterface

// File: rtl/commit_store_queue.sv
// commit_store_queue
//   Buffers stores between execution and architectural commit, then drains
//   committed stores to the D$ in program order. A circular buffer holds
//   speculative entries [commit_ptr, alloc_ptr) and committed entries
//   [drain_ptr, commit_ptr). Flush drops only the speculative region.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   bus    : commit_store_queue_if.slave
//            st_*        LSU allocation (valid/ready + paddr/data/be/size)
//            commit_*    promote oldest speculative entry / entries exist
//            no_st_pending_o  no committed entry awaits draining
//            page_offset_*    load hazard probe over all valid entries
//            req_*/gnt_i      D$ write request, payload at drain_ptr
//            flush_i          discard speculative entries
module commit_store_queue #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned PADDR_W = 56
) (
  input  logic          clk_i,
  input  logic          rst_i,
  commit_store_queue_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // pointers and counters
  logic [PW-1:0]      alloc_ptr_q,  alloc_ptr_d;
  logic [PW-1:0]      commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]      drain_ptr_q,  drain_ptr_d;
  logic [CW-1:0]      spec_cnt_q,   spec_cnt_d;
  logic [CW-1:0]      com_cnt_q,    com_cnt_d;
  logic [DEPTH-1:0]   valid_q,      valid_d;

  // entry payload storage
  logic [PADDR_W-1:0] paddr_q [DEPTH];
  logic [63:0]        data_q  [DEPTH];
  logic [7:0]         be_q    [DEPTH];
  logic [1:0]         size_q  [DEPTH];

  // handshake terms
  logic [CW-1:0]      occupancy;
  logic               st_ready;
  logic               commit_ready;
  logic               req;
  logic               alloc_fire;
  logic               commit_fire;
  logic               drain_fire;

  // flush bookkeeping
  logic [CW-1:0]      flush_keep;
  logic [PW-1:0]      flush_off;

  logic               match;
  logic               unused_po_low;

  // All handshake terms come from registered counters, so gnt_i never
  // reaches st_ready_o or any other output combinationally.
  always_comb begin
    occupancy    = spec_cnt_q + com_cnt_q;
    st_ready     = occupancy < CW'(DEPTH);
    commit_ready = spec_cnt_q != '0;
    req          = com_cnt_q != '0;
    alloc_fire   = bus.st_valid_i && st_ready && !bus.flush_i;
    commit_fire  = bus.commit_i && commit_ready;
    drain_fire   = req && bus.gnt_i;
  end

  always_comb begin
    commit_ptr_d = commit_ptr_q + PW'(commit_fire);
    drain_ptr_d  = drain_ptr_q + PW'(drain_fire);
    com_cnt_d    = com_cnt_q + CW'(commit_fire) - CW'(drain_fire);
    alloc_ptr_d  = alloc_ptr_q;
    spec_cnt_d   = spec_cnt_q;
    valid_d      = valid_q;
    // Speculative entries still present after this cycle's commit; these
    // are the slots a flush must invalidate, starting at commit_ptr_d.
    flush_keep   = spec_cnt_q - CW'(commit_fire);
    flush_off    = '0;

    if (drain_fire) begin
      valid_d[drain_ptr_q] = 1'b0;
    end

    if (bus.flush_i) begin
      // A same-cycle commit is honoured first; allocation is suppressed
      // via alloc_fire, so the speculative region is exactly flush_keep
      // slots long.
      alloc_ptr_d = commit_ptr_d;
      spec_cnt_d  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        flush_off = PW'(i) - commit_ptr_d;
        if (CW'(flush_off) < flush_keep) begin
          valid_d[i] = 1'b0;
        end
      end
    end else begin
      alloc_ptr_d = alloc_ptr_q + PW'(alloc_fire);
      spec_cnt_d  = spec_cnt_q + CW'(alloc_fire) - CW'(commit_fire);
      if (alloc_fire) begin
        valid_d[alloc_ptr_q] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alloc_ptr_q  <= '0;
      commit_ptr_q <= '0;
      drain_ptr_q  <= '0;
      spec_cnt_q   <= '0;
      com_cnt_q    <= '0;
      valid_q      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        paddr_q[i] <= '0;
        data_q[i]  <= '0;
        be_q[i]    <= '0;
        size_q[i]  <= '0;
      end
    end else begin
      alloc_ptr_q  <= alloc_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      drain_ptr_q  <= drain_ptr_d;
      spec_cnt_q   <= spec_cnt_d;
      com_cnt_q    <= com_cnt_d;
      valid_q      <= valid_d;
      if (alloc_fire) begin
        paddr_q[alloc_ptr_q] <= bus.st_paddr_i;
        data_q[alloc_ptr_q]  <= bus.st_data_i;
        be_q[alloc_ptr_q]    <= bus.st_be_i;
        size_q[alloc_ptr_q]  <= bus.st_size_i;
      end
    end
  end

  // Hazard probe compares the 8-byte-aligned page offset of every valid
  // entry, speculative or committed.
  always_comb begin
    match = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (paddr_q[i][11:3] == bus.page_offset_i[11:3])) begin
        match = 1'b1;
      end
    end
  end

  // Sub-doubleword offset bits play no part in the hazard check.
  assign unused_po_low = ^bus.page_offset_i[2:0];

  assign bus.st_ready_o          = st_ready;
  assign bus.commit_ready_o      = commit_ready;
  assign bus.no_st_pending_o     = !req;
  assign bus.page_offset_match_o = match;
  assign bus.req_o               = req;
  assign bus.req_paddr_o         = paddr_q[drain_ptr_q];
  assign bus.req_data_o          = data_q[drain_ptr_q];
  assign bus.req_be_o            = be_q[drain_ptr_q];
  assign bus.req_size_o          = size_q[drain_ptr_q];

endmodule

// File: tb/tb_commit_store_queue.sv
module tb_commit_store_queue;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   idx;

  commit_store_queue_if #(.PADDR_W(56)) bus_if ();

  commit_store_queue #(.DEPTH(8), .PADDR_W(56)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus_if.flush_i       = 1'b0;
    bus_if.st_valid_i    = 1'b0;
    bus_if.st_paddr_i    = '0;
    bus_if.st_data_i     = '0;
    bus_if.st_be_i       = '0;
    bus_if.st_size_i     = '0;
    bus_if.commit_i      = 1'b0;
    bus_if.gnt_i         = 1'b0;
  endtask

  task automatic put(input logic [55:0] pa, input logic [63:0] d, input logic [7:0] be,
                     input logic [1:0] sz);
    bus_if.st_valid_i = 1'b1;
    bus_if.st_paddr_i = pa;
    bus_if.st_data_i  = d;
    bus_if.st_be_i    = be;
    bus_if.st_size_i  = sz;
  endtask

  task automatic probe(input logic [11:0] po);
    bus_if.page_offset_i = po;
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    idx   = 0;
    rst   = 1'b1;
    idle();
    bus_if.page_offset_i = '0;
    step();
    step();
    rst = 1'b0;
    #1;

    // reset state
    chk("rst_st_ready", 64'(bus_if.st_ready_o), 64'd1);
    chk("rst_commit_ready", 64'(bus_if.commit_ready_o), 64'd0);
    chk("rst_no_st_pending", 64'(bus_if.no_st_pending_o), 64'd1);
    chk("rst_match", 64'(bus_if.page_offset_match_o), 64'd0);
    chk("rst_req", 64'(bus_if.req_o), 64'd0);
    chk("rst_req_paddr", 64'(bus_if.req_paddr_o), 64'd0);
    chk("rst_req_data", bus_if.req_data_o, 64'd0);
    chk("rst_req_be", 64'(bus_if.req_be_o), 64'd0);

    // single store
    put(56'h1008, 64'hDEADBEEF, 8'h0F, 2'd2);
    step();
    idle();
    chk("s1_commit_ready", 64'(bus_if.commit_ready_o), 64'd1);
    chk("s1_req_before_commit", 64'(bus_if.req_o), 64'd0);
    probe(12'h00C);
    chk("s1_match_spec", 64'(bus_if.page_offset_match_o), 64'd1);
    step();
    step();
    step();
    bus_if.commit_i = 1'b1;
    bus_if.gnt_i    = 1'b1;
    step();
    bus_if.commit_i = 1'b0;
    chk("s1_req", 64'(bus_if.req_o), 64'd1);
    chk("s1_paddr", 64'(bus_if.req_paddr_o), 64'h1008);
    chk("s1_data", bus_if.req_data_o, 64'hDEADBEEF);
    chk("s1_be", 64'(bus_if.req_be_o), 64'h0F);
    chk("s1_size", 64'(bus_if.req_size_o), 64'd2);
    chk("s1_pending", 64'(bus_if.no_st_pending_o), 64'd0);
    step();
    bus_if.gnt_i = 1'b0;
    chk("s1_req_done", 64'(bus_if.req_o), 64'd0);
    chk("s1_no_pending", 64'(bus_if.no_st_pending_o), 64'd1);
    probe(12'h00C);
    chk("s1_match_gone", 64'(bus_if.page_offset_match_o), 64'd0);

    // fill to full, attempt a ninth store
    for (int k = 0; k < 8; k++) begin
      put(56'h3000 + 56'(k * 8), 64'hA0 + 64'(k), 8'hFF, 2'd3);
      #1;
      chk("fill_ready", 64'(bus_if.st_ready_o), 64'd1);
      step();
    end
    put(56'hBAD0, 64'hBAD, 8'h01, 2'd0);
    #1;
    chk("full_ready", 64'(bus_if.st_ready_o), 64'd0);
    chk("full_commit_ready", 64'(bus_if.commit_ready_o), 64'd1);
    step();
    idle();
    chk("full_ready_held", 64'(bus_if.st_ready_o), 64'd0);
    bus_if.commit_i = 1'b1;
    for (int k = 0; k < 8; k++) step();
    bus_if.commit_i = 1'b0;
    chk("full_all_committed", 64'(bus_if.commit_ready_o), 64'd0);
    chk("full_req", 64'(bus_if.req_o), 64'd1);
    chk("full_head_paddr", 64'(bus_if.req_paddr_o), 64'h3000);
    bus_if.gnt_i = 1'b1;
    #1;
    chk("full_no_gnt_path", 64'(bus_if.st_ready_o), 64'd0);
    step();
    chk("full_ready_after_drain", 64'(bus_if.st_ready_o), 64'd1);
    for (int k = 1; k < 8; k++) begin
      chk("full_drain_paddr", 64'(bus_if.req_paddr_o), 64'h3000 + 64'(k * 8));
      chk("full_drain_data", bus_if.req_data_o, 64'hA0 + 64'(k));
      step();
    end
    bus_if.gnt_i = 1'b0;
    chk("full_empty_req", 64'(bus_if.req_o), 64'd0);
    chk("full_empty_pending", 64'(bus_if.no_st_pending_o), 64'd1);

    // flush with same-cycle commit and allocation
    put(56'h4010, 64'h1, 8'hFF, 2'd3);
    step();
    put(56'h4020, 64'h2, 8'hFF, 2'd3);
    step();
    put(56'h4030, 64'h3, 8'hFF, 2'd3);
    step();
    idle();
    bus_if.commit_i = 1'b1;
    step();
    put(56'h4040, 64'h4, 8'hFF, 2'd3);
    bus_if.flush_i  = 1'b1;
    bus_if.commit_i = 1'b1;
    step();
    idle();
    chk("fl_spec_zero", 64'(bus_if.commit_ready_o), 64'd0);
    chk("fl_pending", 64'(bus_if.no_st_pending_o), 64'd0);
    chk("fl_req_paddr", 64'(bus_if.req_paddr_o), 64'h4010);
    probe(12'h030);
    chk("fl_match_flushed", 64'(bus_if.page_offset_match_o), 64'd0);
    probe(12'h040);
    chk("fl_match_dropped", 64'(bus_if.page_offset_match_o), 64'd0);
    probe(12'h020);
    chk("fl_match_kept", 64'(bus_if.page_offset_match_o), 64'd1);
    bus_if.gnt_i = 1'b1;
    step();
    chk("fl_second_paddr", 64'(bus_if.req_paddr_o), 64'h4020);
    step();
    bus_if.gnt_i = 1'b0;
    chk("fl_req_done", 64'(bus_if.req_o), 64'd0);
    put(56'h4050, 64'h5, 8'hFF, 2'd3);
    step();
    idle();
    bus_if.commit_i = 1'b1;
    step();
    bus_if.commit_i = 1'b0;
    chk("fl_realloc_paddr", 64'(bus_if.req_paddr_o), 64'h4050);
    bus_if.gnt_i = 1'b1;
    step();
    bus_if.gnt_i = 1'b0;
    chk("fl_realloc_done", 64'(bus_if.req_o), 64'd0);

    // back-pressure
    put(56'h6008, 64'h1111, 8'h0F, 2'd2);
    step();
    put(56'h6010, 64'h2222, 8'hF0, 2'd2);
    bus_if.commit_i = 1'b1;
    step();
    bus_if.st_valid_i = 1'b0;
    step();
    idle();
    for (int k = 0; k < 5; k++) begin
      chk("bp_req_held", 64'(bus_if.req_o), 64'd1);
      chk("bp_paddr_stable", 64'(bus_if.req_paddr_o), 64'h6008);
      chk("bp_data_stable", bus_if.req_data_o, 64'h1111);
      step();
    end
    bus_if.gnt_i = 1'b1;
    chk("bp_first", 64'(bus_if.req_paddr_o), 64'h6008);
    step();
    chk("bp_second", 64'(bus_if.req_paddr_o), 64'h6010);
    chk("bp_second_be", 64'(bus_if.req_be_o), 64'hF0);
    step();
    bus_if.gnt_i = 1'b0;
    chk("bp_req_low", 64'(bus_if.req_o), 64'd0);

    // wrap with allocate/commit/drain every cycle
    idx = 0;
    for (int c = 0; c < 30; c++) begin
      if (c < 20) put(56'h5000 + 56'(c * 8), 64'(c), 8'hFF, 2'd3);
      else bus_if.st_valid_i = 1'b0;
      bus_if.commit_i = 1'b1;
      bus_if.gnt_i    = 1'b1;
      #1;
      chk("wr_ready", 64'(bus_if.st_ready_o), 64'd1);
      if (bus_if.req_o) begin
        chk("wr_order", 64'(bus_if.req_paddr_o), 64'h5000 + 64'(idx * 8));
        idx++;
      end
      step();
    end
    idle();
    chk("wr_count", 64'(idx), 64'd20);
    chk("wr_req_low", 64'(bus_if.req_o), 64'd0);

    // page-offset match and mid-operation reset
    put(56'h2A48, 64'h77, 8'hFF, 2'd3);
    step();
    probe(12'hA4C);
    chk("m_match_hit", 64'(bus_if.page_offset_match_o), 64'd1);
    probe(12'hA50);
    chk("m_match_miss", 64'(bus_if.page_offset_match_o), 64'd0);
    put(56'h2A58, 64'h88, 8'hFF, 2'd3);
    bus_if.commit_i = 1'b1;
    step();
    bus_if.st_valid_i = 1'b0;
    step();
    idle();
    chk("m_req_before_rst", 64'(bus_if.req_o), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    probe(12'hA4C);
    chk("m_rst_req", 64'(bus_if.req_o), 64'd0);
    chk("m_rst_no_pending", 64'(bus_if.no_st_pending_o), 64'd1);
    chk("m_rst_commit_ready", 64'(bus_if.commit_ready_o), 64'd0);
    chk("m_rst_match", 64'(bus_if.page_offset_match_o), 64'd0);
    chk("m_rst_paddr", 64'(bus_if.req_paddr_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/commit_store_queue.md
# commit_store_queue

Holds stores from the load/store unit between execution and architectural commit, then drains committed stores to the data cache in program order. It sits directly downstream of the commit stage: the commit stage's `commit_lsu` pulse promotes the oldest speculative store to committed, and the commit stage's `commit_lsu_ready` and `no_st_pending` inputs are driven from here. A pipeline flush discards all speculative entries. Committed entries always survive and drain.

## Interface
Parameters:
- `DEPTH`, 8, number of entries. Must be a power of two, at least 2.
- `PADDR_W`, 56, physical address width.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous reset, active-high.
- `flush_i` in 1: discard all speculative (uncommitted) entries.
- `st_valid_i` in 1: LSU presents a store for allocation.
- `st_ready_o` out 1: queue can accept the store. High when the queue is not full.
- `st_paddr_i` in `PADDR_W`: store physical address.
- `st_data_i` in 64: store data.
- `st_be_i` in 8: byte enables.
- `st_size_i` in 2: access size.
- `commit_i` in 1: commit the oldest speculative entry.
- `commit_ready_o` out 1: at least one speculative entry exists.
- `no_st_pending_o` out 1: no committed entry awaits draining.
- `page_offset_i` in 12: load page offset, used for the forwarding/hazard check.
- `page_offset_match_o` out 1: some valid entry has `paddr[11:3] == page_offset_i[11:3]`.
- `req_o` out 1: write request to the D$.
- `gnt_i` in 1: D$ accepts the request.
- `req_paddr_o` out `PADDR_W`: request address.
- `req_data_o` out 64: request data.
- `req_be_o` out 8: request byte enables.
- `req_size_o` out 2: request size.

## Operation
- Storage is a circular buffer of `DEPTH` entries. Each entry holds paddr, data, be, size and a valid bit.
- Three pointers of width `$clog2(DEPTH)` track the buffer; all wrap modulo `DEPTH`:
  - `alloc_ptr`: next free slot.
  - `commit_ptr`: oldest speculative entry.
  - `drain_ptr`: oldest committed entry.
- Two counters of width `$clog2(DEPTH)+1`:
  - `spec_cnt`: entries from `commit_ptr` to `alloc_ptr`.
  - `com_cnt`: entries from `drain_ptr` to `commit_ptr`.
- Allocate: when `st_valid_i && st_ready_o`, write the slot at `alloc_ptr`, set its valid bit, increment `alloc_ptr`, and increment `spec_cnt`. `st_ready_o = (spec_cnt + com_cnt) < DEPTH`.
- Commit: when `commit_i && commit_ready_o`, increment `commit_ptr`, move one count from `spec_cnt` to `com_cnt`. `commit_i` while `spec_cnt == 0` is ignored.
- Drain: `req_o = (com_cnt != 0)`. The payload is the entry at `drain_ptr`. On `req_o && gnt_i`, clear that entry's valid bit, increment `drain_ptr`, and decrement `com_cnt`. The payload stays stable while `req_o` is high and `gnt_i` is low.
- Flush: set `alloc_ptr` to the post-commit `commit_ptr`, set `spec_cnt` to 0, and clear the valid bits of the discarded slots. Same-cycle ordering:
  - A commit in the flush cycle is applied first, so that entry is kept.
  - An allocation in the flush cycle is dropped.
- Allocate, commit and drain may all occur in the same cycle. Counters are updated by the net delta.
- Full queue: `st_ready_o = 0`. If a drain frees a slot this cycle, `st_ready_o` still stays 0 this cycle; there is no combinational path from `gnt_i` to `st_ready_o`.
- `no_st_pending_o = (com_cnt == 0)`.
- `page_offset_match_o` is the OR across all valid entries, both speculative and committed.

## Timing
- Reset values:
  - All pointers, counters and valid bits are 0.
  - `st_ready_o=1`, `commit_ready_o=0`, `no_st_pending_o=1`, `page_offset_match_o=0`, `req_o=0`.
  - Request payload outputs are 0; stored entry payloads are cleared.
- Reset mid-operation discards everything, including committed entries not yet granted.
- A store allocated at edge N gives `commit_ready_o=1` in cycle N+1.
- A commit at edge N gives `req_o=1` in cycle N+1. Commit-to-request latency is 1 cycle; throughput is one grant per cycle.
- `req_o` and the payload depend only on registers. `gnt_i` has no combinational path to any output.
- `page_offset_match_o` is combinational from `page_offset_i`. A store allocated at edge N is visible to the match from cycle N+1.

## Test plan
- Single store: allocate (paddr 0x1008, data 0xDEADBEEF, be 0x0F), wait 3 cycles, commit, hold `gnt_i=1`.
  - Expect `req_o` one cycle after the commit edge with the same payload.
  - Expect `no_st_pending_o` back to 1 after the grant.
- Fill and full: 8 allocations with no commits, then a 9th store.
  - Expect `st_ready_o=0` with all pointers unchanged.
  - Commit 8, grant 1: expect `st_ready_o=1` the next cycle.
- Flush: allocate 3 stores, commit 1, then flush with `commit_i=1` and `st_valid_i=1` in the same cycle.
  - Expect `com_cnt=2` and `spec_cnt=0`; the dropped store is never requested.
- Back-pressure: 2 committed stores, `gnt_i=0` for 5 cycles.
  - Expect payload stable and `req_o` held.
  - Then `gnt_i=1` for 2 cycles: both drain in order, then `req_o=0`.
- Wrap and concurrency: 20 stores with allocate, commit and drain every cycle.
  - Expect D$ order to match allocation order across pointer wrap.
  - Expect counters never to exceed 8.
- Match and reset: entry at paddr 0x2A48, `page_offset_i=0xA4C`.
  - Expect `page_offset_match_o=1`; with `0xA50`, expect 0.
  - Assert `rst_i` while 2 entries are committed: the next cycle shows `req_o=0` and `no_st_pending_o=1`.
